// File: rtl/cpu_test_sequencer.sv
// cpu_test_sequencer: sequences a CPU through reset/run phases and checks its OUT stream against a table
module cpu_test_sequencer #(
    parameter int DATA_W         = 32,
    parameter int NUM_CHECKS     = 8,
    parameter int RESET_CYCLES   = 2,
    parameter int TIMEOUT_CYCLES = 4096,
    parameter int AW             = (NUM_CHECKS > 1) ? $clog2(NUM_CHECKS) : 1,
    parameter int CW             = $clog2(NUM_CHECKS + 1)
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic [DATA_W-1:0] in_value,
    input  logic [CW-1:0]     num_checks,
    input  logic              exp_we,
    input  logic [AW-1:0]     exp_addr,
    input  logic [DATA_W-1:0] exp_data,
    input  logic              cpu_run,
    input  logic [DATA_W-1:0] cpu_out,
    output logic              cpu_reset,
    output logic              cpu_stop,
    output logic [DATA_W-1:0] cpu_in,
    output logic              busy,
    output logic              done,
    output logic              pass,
    output logic [2:0]        fail_code,
    output logic [AW-1:0]     fail_index,
    output logic [CW-1:0]     check_count
);
    localparam int TW  = $clog2(TIMEOUT_CYCLES);
    localparam int RCW = $clog2(RESET_CYCLES + 1);

    typedef enum logic [1:0] {IDLE, INIT, TEST, DONE} state_t;

    state_t            state, state_n;
    logic [DATA_W-1:0] tbl [NUM_CHECKS];
    logic [DATA_W-1:0] prev_out;
    logic [CW-1:0]     idx, idx_n, nchk;
    logic [TW-1:0]     timer;
    logic [RCW-1:0]    rcnt;
    logic              run_seen;
    logic              start_ok, init_end;
    logic              ev, in_range, match, mism, halt, tmo, term, fin_pass;
    logic [2:0]        code;

    assign cpu_reset = state == IDLE || state == INIT;
    assign cpu_stop  = state == IDLE || state == DONE;
    assign busy      = state == INIT || state == TEST;
    assign done      = state == DONE;
    assign start_ok  = start && (state == IDLE || state == DONE);
    assign init_end  = state == INIT && rcnt == RCW'(RESET_CYCLES - 1);

    // Per-cycle check of the OUT stream: mismatch/extra beats halt, halt beats timeout
    always_comb begin
        ev       = cpu_out != prev_out;
        in_range = idx < nchk;
        match    = ev && in_range && cpu_out == tbl[idx[AW-1:0]];
        mism     = ev && !match;
        idx_n    = idx + CW'(match);
        halt     = run_seen && !cpu_run;
        tmo      = timer == TW'(TIMEOUT_CYCLES - 1);
        term     = state == TEST && (mism || halt || tmo);
        fin_pass = !mism && halt && idx_n == nchk;
        code     = mism ? (in_range ? 3'd1 : 3'd4) : halt ? (fin_pass ? 3'd0 : 3'd3) : 3'd2;
    end

    // Next-state selection; start is only honoured from IDLE or DONE
    always_comb begin
        state_n = state;
        state_n = start_ok ? INIT : init_end ? TEST : term ? DONE : state;
    end

    // State register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= IDLE;
        else       state <= state_n;
    end

    // Run bookkeeping; TEST-entry values are reloaded every INIT cycle so the last one wins
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cpu_in      <= '0;
            nchk        <= '0;
            pass        <= 1'b0;
            fail_code   <= 3'd0;
            fail_index  <= '0;
            check_count <= '0;
            rcnt        <= '0;
            prev_out    <= '0;
            run_seen    <= 1'b0;
            timer       <= '0;
            idx         <= '0;
        end else begin
            if (start_ok) begin
                cpu_in      <= in_value;
                nchk        <= (num_checks > CW'(NUM_CHECKS)) ? CW'(NUM_CHECKS) : num_checks;
                pass        <= 1'b0;
                fail_code   <= 3'd0;
                fail_index  <= '0;
                check_count <= '0;
                rcnt        <= '0;
            end
            if (state == INIT) begin
                rcnt     <= rcnt + 1'b1;
                prev_out <= cpu_out;
                run_seen <= 1'b0;
                timer    <= '0;
                idx      <= '0;
            end
            if (state == TEST) begin
                prev_out    <= cpu_out;
                run_seen    <= run_seen | cpu_run;
                timer       <= timer + 1'b1;
                idx         <= idx_n;
                check_count <= check_count + CW'(match);
                if (term) begin
                    pass       <= fin_pass;
                    fail_code  <= code;
                    fail_index <= fin_pass ? fail_index : idx[AW-1:0];
                end
            end
        end
    end

    // Expected-value table; frozen while a run is active and never reset
    always_ff @(posedge clk) begin
        if (exp_we && !busy && {1'b0, exp_addr} < (AW + 1)'(NUM_CHECKS)) tbl[exp_addr] <= exp_data;
    end
endmodule
